sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
Input-side counterpart to the SHA256 output data interface (dout_vld/dout[255:0]). Accepts a byte-packed message as a 32-bit word stream with valid/ready and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length. Emits 512-bit blocks with first/last flags to the SHA256 compression core. Sits between the testbench or host data source and the sha256 core input.

Parameters:
LEN_W, 64, width of the internal message bit-length counter; zero-extended into the 64-bit length field.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_vld  in  1  input word valid
in_rdy  out  1  input word ready
in_data  in  32  message word; byte 0 in [31:24]
in_last  in  1  final word of message
in_nbytes  in  3  valid bytes in word, 1..4; 0 legal only with in_last (empty tail)
blk_vld  out  1  block valid
blk_rdy  in  1  core accepts block
blk_data  out  512  block; word 0 in [511:480]
blk_first  out  1  first block of message (core reloads IV)
blk_last  out  1  final padded block (digest follows on dout_vld)
busy  out  1  message in progress (any state other than FILL with wptr==0 and no pending pad)

Behaviour:
- Reset: in_rdy=0 for the reset cycle, then 1. blk_vld=0, blk_data=0, blk_first=0, blk_last=0, busy=0, wptr=0, len=0, first_pend=1.
- Transfer on vld&rdy, both sides. blk_data/flags are stable while blk_vld=1 and blk_rdy=0.
- FSM states: FILL, PAD, LEN, SEND.
- FILL:
  - in_rdy=1. Accepted word is written at wptr; wptr++; len += 8*in_nbytes.
  - If in_last and in_nbytes<4: bytes >= in_nbytes are zeroed and 0x80 is placed at byte in_nbytes; pad_pend=0.
  - If in_last and in_nbytes==4: pad_pend=1.
  - After in_last: go to PAD. Else if wptr wraps to 16: go to SEND with last=0.
- PAD (in_rdy=0, one word per cycle):
  - If wptr==16: SEND with last=0. After acceptance, PAD continues in a fresh block.
  - Else if wptr<=14 and !pad_pend: go to LEN.
  - Else: write the word (0x80000000 if pad_pend, else 0), clear pad_pend, wptr++.
  - wptr==15 with no pad pending writes a zero word, then reaches 16.
- LEN: write words 14/15 = len[63:32]/len[31:0] in one cycle; go to SEND with last=1.
- SEND:
  - blk_vld=1; blk_first=first_pend; blk_last=last.
  - On blk_rdy: buffer cleared, wptr=0, first_pend=0.
  - If last: len=0, first_pend=1, next state FILL. Else return to the origin state (FILL or PAD).
- Latency: block valid 1 cycle after the 16th word is accepted, or after LEN. Throughput: 1 word/cycle with blk_rdy held high.
- Length wraps modulo 2^LEN_W with no error.
- Reset mid-message: all state discarded; no partial block is emitted.
- in_vld with in_nbytes==0 and !in_last: word ignored (no write, no length update), in_rdy still asserted.

Optional Feature:
SHA256_PAD_BYTE_SWAP_EN:
- Defined: in_data is byte-reversed before use (byte 0 taken from [7:0]); in_nbytes counts from the low byte.
- Undefined: in_data is used as-is, big-endian byte order.

Decomposition:
- sha256_pkg holds: BLK_W=512, WORD_W=32, WORDS_PER_BLK=16, LEN_FIELD_W=64, PAD_BYTE=8'h80, the state enum typedef, and the blk_t struct (data, first, last).
- One sub-module, sha256_pad_word_mask: combinational. Takes word and nbytes, returns the masked word with 0x80 inserted. Byte swap is applied here under the macro.

Test Plan:
- "abc" (one word 0x61626300, nbytes=3, last) -> one block; w0=0x61626380, w1..w14=0, w15=0x00000018; first=last=1.
- Empty message (nbytes=0, last) -> one block; w0=0x80000000, w1..w15=0; first=last=1.
- 55 bytes -> one block; byte 55=0x80; w15=0x000001B8.
- 56 bytes -> block 1: first=1, last=0, byte 56=0x80. Block 2: w0..w13=0, w15=0x000001C0, first=0, last=1.
- 64 bytes -> two blocks; block 2 w0=0x80000000, w15=0x00000200. blk_rdy held low 5 cycles: blk_data stable and in_rdy=0 throughout.
- Reset asserted after 7 words -> all outputs return to reset values next cycle. A following "abc" produces a correct single block with first=1.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA256 message padder.
// Block word w lives at packed slot 15-w so that word 0 lands in [511:480].
package sha256_pkg;

    localparam int BLK_W         = 512;
    localparam int WORD_W        = 32;
    localparam int WORDS_PER_BLK = 16;
    localparam int LEN_FIELD_W   = 64;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        FILL,
        PAD,
        LEN,
        SEND
    } state_e;

    typedef struct packed {
        logic [WORDS_PER_BLK-1:0][WORD_W-1:0] data;
        logic                                 first;
        logic                                 last;
    } blk_t;

    function automatic logic [3:0] word_slot(input logic [3:0] wordIdx);
        return ~wordIdx;
    endfunction

endpackage

// File: rtl/sha256_pad_word_mask.sv
// Tail-word shaping: keeps the first nbytes bytes, inserts the 0x80 pad byte, zeroes the rest.
// SHA256_PAD_BYTE_SWAP_EN selects little-endian input byte order.
module sha256_pad_word_mask
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [2:0]        nbytes_i,
    output logic [WORD_W-1:0] swapped_o,
    output logic [WORD_W-1:0] padded_o
);

`ifdef SHA256_PAD_BYTE_SWAP_EN
    assign swapped_o = {word_i[7:0], word_i[15:8], word_i[23:16], word_i[31:24]};
`else
    assign swapped_o = word_i;
`endif

    always_comb begin
        padded_o = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < nbytes_i) begin
                padded_o[31-8*b -: 8] = swapped_o[31-8*b -: 8];
            end else if (3'(b) == nbytes_i) begin
                padded_o[31-8*b -: 8] = PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder: 32-bit word stream in, 512-bit blocks with first/last flags out.
// Optional SHA256_PAD_BYTE_SWAP_EN takes input bytes little-endian (handled in the word mask).
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic [2:0]       in_nbytes,
    output logic             blk_vld,
    input  logic             blk_rdy,
    output logic [BLK_W-1:0] blk_data,
    output logic             blk_first,
    output logic             blk_last,
    output logic             busy
);

    state_e                 state_q;
    state_e                 origin_q;
    logic [4:0]             wptr_q;
    logic [LEN_W-1:0]       len_q;
    logic                   first_pend_q;
    logic                   pad_pend_q;
    logic                   in_rdy_q;
    logic                   blk_vld_q;
    blk_t                   blk_q;

    logic [WORD_W-1:0]      swappedWord;
    logic [WORD_W-1:0]      paddedWord;
    logic [WORD_W-1:0]      in_word_d;
    logic [LEN_FIELD_W-1:0] lenField;
    logic                   accept;
    logic                   skipWord;

    sha256_pad_word_mask u_mask (
        .word_i    (in_data),
        .nbytes_i  (in_nbytes),
        .swapped_o (swappedWord),
        .padded_o  (paddedWord)
    );

    assign accept    = in_vld && in_rdy_q;
    assign skipWord  = (in_nbytes == 3'd0) && !in_last;
    assign in_word_d = (in_last && in_nbytes < 3'd4) ? paddedWord : swappedWord;
    assign lenField  = LEN_FIELD_W'(len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            origin_q     <= FILL;
            wptr_q       <= '0;
            len_q        <= '0;
            first_pend_q <= 1'b1;
            pad_pend_q   <= 1'b0;
            in_rdy_q     <= 1'b0;
            blk_vld_q    <= 1'b0;
            blk_q        <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    in_rdy_q <= 1'b1;
                    if (accept && !skipWord) begin
                        blk_q.data[word_slot(wptr_q[3:0])] <= in_word_d;
                        wptr_q <= wptr_q + 5'd1;
                        len_q  <= len_q + LEN_W'({in_nbytes, 3'b000});
                        if (in_last) begin
                            pad_pend_q <= (in_nbytes >= 3'd4);
                            state_q    <= PAD;
                            in_rdy_q   <= 1'b0;
                        end else if (wptr_q == 5'd15) begin
                            state_q     <= SEND;
                            origin_q    <= FILL;
                            blk_vld_q   <= 1'b1;
                            blk_q.first <= first_pend_q;
                            blk_q.last  <= 1'b0;
                            in_rdy_q    <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    if (wptr_q[4]) begin
                        state_q     <= SEND;
                        origin_q    <= PAD;
                        blk_vld_q   <= 1'b1;
                        blk_q.first <= first_pend_q;
                        blk_q.last  <= 1'b0;
                    end else if (wptr_q <= 5'd14 && !pad_pend_q) begin
                        state_q <= LEN;
                    end else begin
                        blk_q.data[word_slot(wptr_q[3:0])] <=
                            pad_pend_q ? {PAD_BYTE, 24'h0} : '0;
                        pad_pend_q <= 1'b0;
                        wptr_q     <= wptr_q + 5'd1;
                    end
                end
                LEN: begin
                    blk_q.data[word_slot(4'd14)] <= lenField[63:32];
                    blk_q.data[word_slot(4'd15)] <= lenField[31:0];
                    state_q     <= SEND;
                    blk_vld_q   <= 1'b1;
                    blk_q.first <= first_pend_q;
                    blk_q.last  <= 1'b1;
                end
                SEND: begin
                    if (blk_rdy) begin
                        blk_vld_q    <= 1'b0;
                        blk_q        <= '0;
                        wptr_q       <= '0;
                        first_pend_q <= 1'b0;
                        if (blk_q.last) begin
                            len_q        <= '0;
                            first_pend_q <= 1'b1;
                            state_q      <= FILL;
                            in_rdy_q     <= 1'b1;
                        end else begin
                            state_q  <= origin_q;
                            in_rdy_q <= (origin_q == FILL);
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign in_rdy    = in_rdy_q;
    assign blk_vld   = blk_vld_q;
    assign blk_data  = blk_q.data;
    assign blk_first = blk_q.first;
    assign blk_last  = blk_q.last;
    assign busy      = !(state_q == FILL && wptr_q == 5'd0 && !pad_pend_q);

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: byte-level padding model plus literal pins.
// Honours SHA256_PAD_BYTE_SWAP_EN when packing input words.
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_vld;
    logic         in_rdy;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_nbytes;
    logic         blk_vld;
    logic         blk_rdy;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         busy;

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } blkRec_t;

    blkRec_t       expQ[$];
    blkRec_t       gotQ[$];
    byte unsigned  msg[$];
    int            checks = 0;
    int            errors = 0;

    logic [511:0] prevData;
    logic         prevFirst;
    logic         prevLast;
    logic         prevStall = 1'b0;

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .blk_vld   (blk_vld),
        .blk_rdy   (blk_rdy),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [511:0] actual,
                               input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Padding model: message bytes, 0x80, zeros to 56 mod 64, 64-bit big-endian bit count.
    function automatic void buildBlocks(input byte unsigned m[$]);
        byte unsigned p[$];
        logic [63:0]  bitLen;
        int           nb;
        blkRec_t      r;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bitLen = 64'(m.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bitLen[8*i +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            r.data = '0;
            for (int j = 0; j < 64; j++) r.data[511-8*j -: 8] = p[b*64 + j];
            r.first = (b == 0);
            r.last  = (b == nb - 1);
            expQ.push_back(r);
        end
    endfunction

    task automatic sendWord(input logic [31:0] data, input logic [2:0] nb, input logic last);
        int cnt = 0;
        @(negedge clk);
        in_vld    = 1'b1;
`ifdef SHA256_PAD_BYTE_SWAP_EN
        in_data   = {data[7:0], data[15:8], data[23:16], data[31:24]};
`else
        in_data   = data;
`endif
        in_nbytes = nb;
        in_last   = last;
        while (!in_rdy && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_rdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_rdy_timeout: got 0 expected 1 within 300 cycles");
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic applyStimulus(input byte unsigned m[$], input bit insertNull);
        int n  = m.size();
        int nw = (n == 0) ? 1 : (n + 3) / 4;
        logic [31:0] w;
        for (int k = 0; k < nw; k++) begin
            for (int b = 0; b < 4; b++)
                w[31-8*b -: 8] = (4*k + b < n) ? m[4*k + b] : 8'hEE;
            sendWord(w, (k == nw - 1) ? 3'(n - 4*k) : 3'd4, k == nw - 1);
            if (insertNull && k == 0 && nw > 1) sendWord(32'hDEADBEEF, 3'd0, 1'b0);
        end
        @(negedge clk);
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int cnt = 0;
        while (expQ.size() != 0 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput({name, "_drained"}, 512'(expQ.size()), 512'd0);
        repeat (2) @(negedge clk);
        checkOutput({name, "_busy_idle"}, 512'(busy), 512'd0);
    endtask

    // Compare process: every accepted block against the model, stability while stalled.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_vld", 512'(blk_vld), 512'd1);
                checkOutput("stall_data", blk_data, prevData);
                checkOutput("stall_flags", 512'({blk_first, blk_last}), 512'({prevFirst, prevLast}));
            end
            if (blk_vld) checkOutput("in_rdy_during_send", 512'(in_rdy), 512'd0);
            if (blk_vld && blk_rdy) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_block: got block %0h expected none", blk_data);
                end else begin
                    blkRec_t e;
                    blkRec_t g;
                    e = expQ.pop_front();
                    checkOutput("blk_data", blk_data, e.data);
                    checkOutput("blk_first", 512'(blk_first), 512'(e.first));
                    checkOutput("blk_last", 512'(blk_last), 512'(e.last));
                    g.data = blk_data;
                    g.first = blk_first;
                    g.last = blk_last;
                    gotQ.push_back(g);
                end
            end
            prevStall = blk_vld && !blk_rdy;
            prevData  = blk_data;
            prevFirst = blk_first;
            prevLast  = blk_last;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no end expected finish before 400us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [511:0] held;
        int           cnt;
        rst = 1'b1; in_vld = 1'b0; in_data = '0; in_last = 1'b0; in_nbytes = '0; blk_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_rdy", 512'(in_rdy), 512'd0);
        checkOutput("rst_outputs", 512'({blk_vld, blk_first, blk_last, busy}), 512'd0);
        checkOutput("rst_blk_data", blk_data, 512'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_in_rdy", 512'(in_rdy), 512'd1);

        // "abc"
        msg = {8'h61, 8'h62, 8'h63};
        buildBlocks(msg);
        checkOutput("model_abc_w0", 512'(expQ[0].data[511:480]), 512'h61626380);
        checkOutput("model_abc_w15", 512'(expQ[0].data[31:0]), 512'h18);
        applyStimulus(msg, 1'b0);
        waitDrain("abc");
        checkOutput("abc_w0", 512'(gotQ[gotQ.size()-1].data[511:480]), 512'h61626380);
        checkOutput("abc_mid", 512'(gotQ[gotQ.size()-1].data[479:32]), 512'd0);
        checkOutput("abc_w15", 512'(gotQ[gotQ.size()-1].data[31:0]), 512'h18);
        checkOutput("abc_flags", 512'({gotQ[gotQ.size()-1].first, gotQ[gotQ.size()-1].last}), 512'b11);

        // Empty message
        msg = {};
        buildBlocks(msg);
        checkOutput("model_empty", expQ[0].data, {32'h80000000, 480'd0});
        applyStimulus(msg, 1'b0);
        waitDrain("empty");
        checkOutput("empty_blk", gotQ[gotQ.size()-1].data, {32'h80000000, 480'd0});

        // 9 bytes with an ignored zero-byte word after the first word
        msg = {};
        for (int i = 0; i < 9; i++) msg.push_back(8'(8'hA0 + i));
        buildBlocks(msg);
        applyStimulus(msg, 1'b1);
        waitDrain("nine_null");
        checkOutput("nine_w2", 512'(gotQ[gotQ.size()-1].data[447:416]), 512'hA8800000);

        // 55 bytes
        msg = {};
        for (int i = 0; i < 55; i++) msg.push_back(8'(i + 1));
        buildBlocks(msg);
        checkOutput("model_55_w15", 512'(expQ[0].data[31:0]), 512'h1B8);
        applyStimulus(msg, 1'b0);
        waitDrain("len55");
        checkOutput("len55_byte55", 512'(gotQ[gotQ.size()-1].data[511-8*55 -: 8]), 512'h80);
        checkOutput("len55_w15", 512'(gotQ[gotQ.size()-1].data[31:0]), 512'h1B8);

        // 56 bytes
        msg = {};
        for (int i = 0; i < 56; i++) msg.push_back(8'(3*i + 7));
        buildBlocks(msg);
        checkOutput("model_56_nblk", 512'(expQ.size()), 512'd2);
        checkOutput("model_56_b2w15", 512'(expQ[1].data[31:0]), 512'h1C0);
        applyStimulus(msg, 1'b0);
        waitDrain("len56");
        checkOutput("len56_b1_byte56", 512'(gotQ[gotQ.size()-2].data[511-8*56 -: 8]), 512'h80);
        checkOutput("len56_b1_flags", 512'({gotQ[gotQ.size()-2].first, gotQ[gotQ.size()-2].last}), 512'b10);
        checkOutput("len56_b2", gotQ[gotQ.size()-1].data, 512'h1C0);
        checkOutput("len56_b2_flags", 512'({gotQ[gotQ.size()-1].first, gotQ[gotQ.size()-1].last}), 512'b01);

        // 64 bytes with a 5-cycle stall on the first block
        msg = {};
        for (int i = 0; i < 64; i++) msg.push_back(8'(255 - i));
        buildBlocks(msg);
        checkOutput("model_64_b2w0", 512'(expQ[1].data[511:480]), 512'h80000000);
        checkOutput("model_64_b2w15", 512'(expQ[1].data[31:0]), 512'h200);
        blk_rdy = 1'b0;
        applyStimulus(msg, 1'b0);
        cnt = 0;
        while (!blk_vld && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("len64_vld_seen", 512'(blk_vld), 512'd1);
        #2;
        held = blk_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            checkOutput("len64_hold_data", blk_data, held);
            checkOutput("len64_hold_in_rdy", 512'(in_rdy), 512'd0);
        end
        @(negedge clk);
        blk_rdy = 1'b1;
        waitDrain("len64");
        checkOutput("len64_b2_w0", 512'(gotQ[gotQ.size()-1].data[511:480]), 512'h80000000);
        checkOutput("len64_b2_w15", 512'(gotQ[gotQ.size()-1].data[31:0]), 512'h200);

        // Reset after 7 words of an unfinished message
        for (int k = 0; k < 7; k++) sendWord(32'h01020304 * (k + 1), 3'd4, 1'b0);
        @(negedge clk);
        in_vld = 1'b0;
        checkOutput("mid_busy", 512'(busy), 512'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_outputs", 512'({in_rdy, blk_vld, blk_first, blk_last, busy}), 512'd0);
        checkOutput("mid_rst_data", blk_data, 512'd0);
        @(negedge clk);
        rst = 1'b0;
        msg = {8'h61, 8'h62, 8'h63};
        buildBlocks(msg);
        applyStimulus(msg, 1'b0);
        waitDrain("abc_after_rst");
        checkOutput("abc_after_rst_blk", gotQ[gotQ.size()-1].data, {32'h61626380, 448'd0, 32'h18});
        checkOutput("abc_after_rst_first", 512'(gotQ[gotQ.size()-1].first), 512'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
